data_memory_lsu: RTL and testbench

//  Parametrised successor to the single-cycle word data memory: clocked, byte-addressable data RAM

---
 rtl/dmem_pkg.sv | 62 ++++++
 rtl/dmem_byte_ram.sv | 33 +++
 rtl/data_memory_lsu.sv | 130 +++++++++++++
 tb/tb_data_memory_lsu.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the data memory LSU.
//   size_e       : access size encodings (byte / half / word / reserved)
//   ld_meta_t    : load attributes carried alongside the array read
//   lane_en      : byte-lane write enables for a store of a given size/offset
//   is_misaligned: alignment / reserved-size fault detection
//   load_extend  : lane selection and sign/zero extension of a read word
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 3;

    typedef struct packed {
        logic [1:0] lane;
        logic [1:0] size;
        logic       uns;
    } ld_meta_t;

    function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] en;
        case (size)
            SZ_BYTE: en = 4'b0001 << lane;
            SZ_HALF: en = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: en = 4'b1111;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = |lane;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{~uns & b[7]}}, b};
            SZ_HALF: r = {{16{~uns & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: four byte-wide synchronous RAM lanes sharing one word index.
//   clk_i   : clock
//   re_i    : read enable; read data registered at the same edge
//   we_i    : per-lane write enables (lane 0 = bits [7:0])
//   idx_i   : word index
//   wdata_i : write data, lane l taken from bits [8l+7:8l]
//   rdata_o : registered read word
// No reset: contents and the read register are deliberately left uninitialised.
module dmem_byte_ram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic             re_i,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_q;

        always_ff @(posedge clk_i) begin
            if (we_i[l]) mem[idx_i] <= wdata_i[8*l +: 8];
            if (re_i)    rd_q       <= mem[idx_i];
        end

        assign rdata_o[8*l +: 8] = rd_q;
    end

endmodule

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressable data RAM with byte/half/word loads and stores,
// sign/zero extension, alignment faults and a READ_LAT-cycle pipelined result path.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   req_i, we_i         : request valid, 1 = store / 0 = load
//   size_i, unsigned_i  : access size, zero-extend loads when set
//   addr_i, data_i      : byte address, right-justified store data
//   data_o, valid_o     : extended load result and its valid strobe
//   misalign_o          : the request in this result slot faulted (data_o = 0)
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_LAT    = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              valid_o,
    output logic              misalign_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
        $error("data_memory_lsu: READ_LAT must be 1..3");
    end
    if (DEPTH_WORDS < 1 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("data_memory_lsu: DEPTH_WORDS must be a power of two");
    end
    // Address bits above the array index are ignored so accesses wrap.
    if (ADDR_W > IDX_W + 2) begin : g_hi_addr
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr_i[ADDR_W-1:IDX_W+2];
    end

    logic                mis_req;
    logic [3:0]          ram_we;
    logic                ram_re;
    logic [31:0]         ram_wdata;
    logic [31:0]         ram_rdata;
    ld_meta_t            meta_d, meta_q;
    logic [READ_LAT:1]   vld_pipe_d, vld_pipe_q;
    logic [READ_LAT:1]   mis_pipe_d, mis_pipe_q;
    logic [31:0]         res1;
    logic [31:0]         res_out;

    always_comb begin
        mis_req = is_misaligned(size_i, addr_i[1:0]);
        // A store sampled while reset is high is dropped.
        ram_we  = (req_i & we_i & ~mis_req & ~rst_i) ? lane_en(size_i, addr_i[1:0]) : 4'b0000;
        ram_re  = req_i & ~we_i & ~mis_req;
        case (size_i)
            SZ_BYTE: ram_wdata = {4{data_i[7:0]}};
            SZ_HALF: ram_wdata = {2{data_i[15:0]}};
            default: ram_wdata = data_i;
        endcase
        meta_d = '{lane: addr_i[1:0], size: size_i, uns: unsigned_i};
        // Loads and faulting stores both occupy a result slot.
        vld_pipe_d    = '0;
        mis_pipe_d    = '0;
        vld_pipe_d[1] = req_i & (~we_i | mis_req);
        mis_pipe_d[1] = mis_req;
        for (int k = 2; k <= READ_LAT; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            mis_pipe_d[k] = mis_pipe_q[k-1];
        end
    end

    dmem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk_i   (clk_i),
        .re_i    (ram_re),
        .we_i    (ram_we),
        .idx_i   (addr_i[IDX_W+1:2]),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe_q <= '0;
            mis_pipe_q <= '0;
            meta_q     <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            mis_pipe_q <= mis_pipe_d;
            meta_q     <= meta_d;
        end
    end

    // The array read lands in stage 1; the extended result rides the later stages.
    always_comb begin
        res1 = mis_pipe_q[1] ? 32'h0 : load_extend(ram_rdata, meta_q.lane, meta_q.size, meta_q.uns);
    end

    if (READ_LAT == 1) begin : g_lat1
        assign res_out = res1;
    end else begin : g_latn
        logic [31:0] res_d [2:READ_LAT];
        logic [31:0] res_q [2:READ_LAT];

        always_comb begin
            res_d[2] = res1;
            for (int k = 3; k <= READ_LAT; k++) res_d[k] = res_q[k-1];
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int k = 2; k <= READ_LAT; k++) res_q[k] <= '0;
            end else begin
                res_q <= res_d;
            end
        end

        assign res_out = res_q[READ_LAT];
    end

    always_comb begin
        valid_o    = vld_pipe_q[READ_LAT];
        misalign_o = valid_o & mis_pipe_q[READ_LAT];
        data_o     = valid_o ? res_out : 32'h0;
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: directed tests for data_memory_lsu.
// Two instances share one stimulus stream: dut3 (16 words, READ_LAT=3) and
// dut1 (defaults: 1024 words, READ_LAT=1). Result pulses are logged each cycle
// and compared against hand-written expected values per scenario.
module tb_data_memory_lsu;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0, we_i = 1'b0, unsigned_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic [31:0] addr_i = '0, data_i = '0;
    logic [31:0] d3, d1;
    logic        v3, v1, m3, m1;

    data_memory_lsu #(.DEPTH_WORDS(16), .READ_LAT(3), .ADDR_W(32)) dut3 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .data_i(data_i),
        .data_o(d3), .valid_o(v3), .misalign_o(m3));

    data_memory_lsu dut1 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .data_i(data_i),
        .data_o(d1), .valid_o(v1), .misalign_o(m1));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int          q3_c[$], q1_c[$], e_c[$];
    logic [31:0] q3_d[$], q1_d[$], e_d[$];
    logic        q3_m[$], q1_m[$], e_m[$];

    // Log result pulses 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (v3 === 1'b1) begin q3_c.push_back(cyc); q3_d.push_back(d3); q3_m.push_back(m3); end
        if (v1 === 1'b1) begin q1_c.push_back(cyc); q1_d.push_back(d1); q1_m.push_back(m1); end
    end

    // Drive one request at the falling edge; rc is the cycle whose rising edge samples it.
    task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, output int rc);
        @(negedge clk);
        req_i = 1'b1; we_i = w; size_i = sz; unsigned_i = u; addr_i = a; data_i = d;
        rc = cyc + 1;
    endtask

    task automatic ld(input logic [1:0] sz, input logic u, input logic [31:0] a,
                      input logic [31:0] xd, input logic xm);
        int rc;
        drive(1'b0, sz, u, a, 32'h0, rc);
        e_c.push_back(rc); e_d.push_back(xd); e_m.push_back(xm);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                      input logic fault);
        int rc;
        drive(1'b1, sz, 1'b0, a, d, rc);
        if (fault) begin e_c.push_back(rc); e_d.push_back(32'h0); e_m.push_back(1'b1); end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); req_i = 1'b0; we_i = 1'b0; end
    endtask

    task automatic clear_q();
        q3_c.delete(); q3_d.delete(); q3_m.delete();
        q1_c.delete(); q1_d.delete(); q1_m.delete();
        e_c.delete();  e_d.delete();  e_m.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({v3, m3, d3} !== 34'h0) begin
            n_bad++; $display("FAIL reset dut3: got v=%b m=%b d=%h want all 0", v3, m3, d3);
        end
        n_cmp++;
        if ({v1, m1, d1} !== 34'h0) begin
            n_bad++; $display("FAIL reset dut1: got v=%b m=%b d=%h want all 0", v1, m1, d1);
        end
        rst_i = 1'b0;
        idle(2);
        n_cmp++;
        if ({v3, m3, d3, v1, m1, d1} !== 68'h0) begin
            n_bad++; $display("FAIL idle_after_reset: got v3=%b v1=%b want 0", v3, v1);
        end
    endtask

    // Word store then load of the same word in the very next cycle.
    task automatic test_word_rw();
        clear_q();
        st(SZ_WORD, 32'h10, 32'hDEADBEEF, 1'b0);
        ld(SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        idle(6);
        n_cmp++;
        if (q3_d.size() != e_d.size()) begin
            n_bad++; $display("FAIL word_rw dut3 pulses: got %0d want %0d", q3_d.size(), e_d.size());
        end else foreach (e_d[i]) begin
            n_cmp++;
            if (q3_c[i] !== e_c[i] + 2 || q3_d[i] !== e_d[i] || q3_m[i] !== e_m[i]) begin
                n_bad++; $display("FAIL word_rw dut3 #%0d: got cyc %0d d %h m %b want cyc %0d d %h m %b",
                                  i, q3_c[i], q3_d[i], q3_m[i], e_c[i] + 2, e_d[i], e_m[i]);
            end
        end
        n_cmp++;
        if (q1_d.size() != e_d.size()) begin
            n_bad++; $display("FAIL word_rw dut1 pulses: got %0d want %0d", q1_d.size(), e_d.size());
        end else foreach (e_d[i]) begin
            n_cmp++;
            if (q1_c[i] !== e_c[i] || q1_d[i] !== e_d[i] || q1_m[i] !== e_m[i]) begin
                n_bad++; $display("FAIL word_rw dut1 #%0d: got cyc %0d d %h m %b want cyc %0d d %h m %b",
                                  i, q1_c[i], q1_d[i], q1_m[i], e_c[i], e_d[i], e_m[i]);
            end
        end
    endtask

    // Byte store into lane 3, then lane extraction with sign and zero extension.
    task automatic test_byte_lanes();
        clear_q();
        st(SZ_WORD, 32'h10, 32'h11223344, 1'b0);
        st(SZ_BYTE, 32'h13, 32'h123456AA, 1'b0);
        ld(SZ_WORD, 1'b0, 32'h10, 32'hAA223344, 1'b0);
        ld(SZ_BYTE, 1'b0, 32'h13, 32'hFFFFFFAA, 1'b0);
        ld(SZ_BYTE, 1'b1, 32'h13, 32'h000000AA, 1'b0);
        ld(SZ_BYTE, 1'b1, 32'h11, 32'h00000033, 1'b0);
        ld(SZ_HALF, 1'b0, 32'h10, 32'h00003344, 1'b0);
        ld(SZ_HALF, 1'b0, 32'h12, 32'hFFFFAA22, 1'b0);
        idle(6);
        n_cmp++;
        if (q3_d.size() != e_d.size()) begin
            n_bad++; $display("FAIL byte_lanes dut3 pulses: got %0d want %0d", q3_d.size(), e_d.size());
        end else foreach (e_d[i]) begin
            n_cmp++;
            if (q3_c[i] !== e_c[i] + 2 || q3_d[i] !== e_d[i] || q3_m[i] !== e_m[i]) begin
                n_bad++; $display("FAIL byte_lanes dut3 #%0d: got cyc %0d d %h m %b want cyc %0d d %h m %b",
                                  i, q3_c[i], q3_d[i], q3_m[i], e_c[i] + 2, e_d[i], e_m[i]);
            end
        end
        n_cmp++;
        if (q1_d.size() != e_d.size()) begin
            n_bad++; $display("FAIL byte_lanes dut1 pulses: got %0d want %0d", q1_d.size(), e_d.size());
        end else foreach (e_d[i]) begin
            n_cmp++;
            if (q1_c[i] !== e_c[i] || q1_d[i] !== e_d[i] || q1_m[i] !== e_m[i]) begin
                n_bad++; $display("FAIL byte_lanes dut1 #%0d: got cyc %0d d %h m %b want cyc %0d d %h m %b",
                                  i, q1_c[i], q1_d[i], q1_m[i], e_c[i], e_d[i], e_m[i]);
            end
        end
    endtask

    // Half store, misaligned half load, faulting word store, reserved size.
    task automatic test_half_fault();
        clear_q();
        st(SZ_WORD, 32'h20, 32'h55667788, 1'b0);
        st(SZ_WORD, 32'h24, 32'h99AABBCC, 1'b0);
        st(SZ_HALF, 32'h22, 32'h00008001, 1'b0);
        ld(SZ_HALF, 1'b0, 32'h22, 32'hFFFF8001, 1'b0);
        ld(SZ_HALF, 1'b1, 32'h22, 32'h00008001, 1'b0);
        ld(SZ_HALF, 1'b0, 32'h21, 32'h00000000, 1'b1);
        st(SZ_WORD, 32'h26, 32'hCAFEF00D, 1'b1);
        ld(SZ_WORD, 1'b0, 32'h20, 32'h80017788, 1'b0);
        ld(SZ_WORD, 1'b0, 32'h24, 32'h99AABBCC, 1'b0);
        ld(SZ_RSVD, 1'b0, 32'h20, 32'h00000000, 1'b1);
        ld(SZ_BYTE, 1'b0, 32'h20, 32'hFFFFFF88, 1'b0);
        idle(6);
        n_cmp++;
        if (q3_d.size() != e_d.size()) begin
            n_bad++; $display("FAIL half_fault dut3 pulses: got %0d want %0d", q3_d.size(), e_d.size());
        end else foreach (e_d[i]) begin
            n_cmp++;
            if (q3_c[i] !== e_c[i] + 2 || q3_d[i] !== e_d[i] || q3_m[i] !== e_m[i]) begin
                n_bad++; $display("FAIL half_fault dut3 #%0d: got cyc %0d d %h m %b want cyc %0d d %h m %b",
                                  i, q3_c[i], q3_d[i], q3_m[i], e_c[i] + 2, e_d[i], e_m[i]);
            end
        end
        n_cmp++;
        if (q1_d.size() != e_d.size()) begin
            n_bad++; $display("FAIL half_fault dut1 pulses: got %0d want %0d", q1_d.size(), e_d.size());
        end else foreach (e_d[i]) begin
            n_cmp++;
            if (q1_c[i] !== e_c[i] || q1_d[i] !== e_d[i] || q1_m[i] !== e_m[i]) begin
                n_bad++; $display("FAIL half_fault dut1 #%0d: got cyc %0d d %h m %b want cyc %0d d %h m %b",
                                  i, q1_c[i], q1_d[i], q1_m[i], e_c[i], e_d[i], e_m[i]);
            end
        end
    endtask

    // Eight loads on consecutive cycles must return in issue order, one pulse each.
    task automatic test_back_to_back();
        int order [8] = '{5, 0, 7, 2, 6, 1, 4, 3};
        clear_q();
        for (int i = 0; i < 8; i++) st(SZ_WORD, 32'(i * 4), 32'hA5000000 + 32'(i * 32'h010101), 1'b0);
        for (int i = 0; i < 8; i++)
            ld(SZ_WORD, 1'b0, 32'(order[i] * 4), 32'hA5000000 + 32'(order[i] * 32'h010101), 1'b0);
        idle(6);
        n_cmp++;
        if (q3_d.size() != e_d.size()) begin
            n_bad++; $display("FAIL back_to_back dut3 pulses: got %0d want %0d", q3_d.size(), e_d.size());
        end else foreach (e_d[i]) begin
            n_cmp++;
            if (q3_c[i] !== e_c[i] + 2 || q3_d[i] !== e_d[i] || q3_m[i] !== e_m[i]) begin
                n_bad++; $display("FAIL back_to_back dut3 #%0d: got cyc %0d d %h m %b want cyc %0d d %h m %b",
                                  i, q3_c[i], q3_d[i], q3_m[i], e_c[i] + 2, e_d[i], e_m[i]);
            end
        end
        n_cmp++;
        if (q1_d.size() != e_d.size()) begin
            n_bad++; $display("FAIL back_to_back dut1 pulses: got %0d want %0d", q1_d.size(), e_d.size());
        end else foreach (e_d[i]) begin
            n_cmp++;
            if (q1_c[i] !== e_c[i] || q1_d[i] !== e_d[i] || q1_m[i] !== e_m[i]) begin
                n_bad++; $display("FAIL back_to_back dut1 #%0d: got cyc %0d d %h m %b want cyc %0d d %h m %b",
                                  i, q1_c[i], q1_d[i], q1_m[i], e_c[i], e_d[i], e_m[i]);
            end
        end
    endtask

    // 16-word instance: 0x40 aliases word 0. Only dut3 wraps, so dut1 is not checked here.
    task automatic test_wrap();
        clear_q();
        st(SZ_WORD, 32'h40, 32'h0BADF00D, 1'b0);
        ld(SZ_WORD, 1'b0, 32'h00, 32'h0BADF00D, 1'b0);
        ld(SZ_BYTE, 1'b1, 32'h03, 32'h0000000B, 1'b0);
        idle(6);
        n_cmp++;
        if (q3_d.size() != e_d.size()) begin
            n_bad++; $display("FAIL wrap dut3 pulses: got %0d want %0d", q3_d.size(), e_d.size());
        end else foreach (e_d[i]) begin
            n_cmp++;
            if (q3_c[i] !== e_c[i] + 2 || q3_d[i] !== e_d[i] || q3_m[i] !== e_m[i]) begin
                n_bad++; $display("FAIL wrap dut3 #%0d: got cyc %0d d %h m %b want cyc %0d d %h m %b",
                                  i, q3_c[i], q3_d[i], q3_m[i], e_c[i] + 2, e_d[i], e_m[i]);
            end
        end
    endtask

    // Async reset while dut3 has two loads in flight; a store under reset is dropped.
    task automatic test_reset_inflight();
        int rc0, rc1;
        clear_q();
        drive(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, rc0);
        drive(1'b0, SZ_WORD, 1'b0, 32'h24, 32'h0, rc1);
        @(negedge clk); req_i = 1'b0;
        @(posedge clk); #3;
        n_cmp++;
        if (v3 !== 1'b1 || d3 !== 32'h80017788) begin
            n_bad++; $display("FAIL rst_pre dut3: got v=%b d=%h want v=1 d=80017788", v3, d3);
        end
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({v3, m3, d3} !== 34'h0) begin
            n_bad++; $display("FAIL rst_drop dut3: got v=%b m=%b d=%h want all 0", v3, m3, d3);
        end
        n_cmp++;
        if ({v1, m1, d1} !== 34'h0) begin
            n_bad++; $display("FAIL rst_drop dut1: got v=%b m=%b d=%h want all 0", v1, m1, d1);
        end
        drive(1'b1, SZ_WORD, 1'b0, 32'h24, 32'hDEAD0000, rc1);
        @(negedge clk); req_i = 1'b0; we_i = 1'b0; rst_i = 1'b0;
        idle(6);
        n_cmp++;
        if (q3_c.size() != 1 || q3_c[0] != rc0 + 2) begin
            n_bad++; $display("FAIL rst_no_late_pulse dut3: got %0d pulses want 1 at cyc %0d", q3_c.size(), rc0 + 2);
        end
        n_cmp++;
        if (q1_c.size() != 2) begin
            n_bad++; $display("FAIL rst_pulses dut1: got %0d pulses want 2", q1_c.size());
        end
        clear_q();
        ld(SZ_WORD, 1'b0, 32'h24, 32'h99AABBCC, 1'b0);
        ld(SZ_WORD, 1'b0, 32'h20, 32'h80017788, 1'b0);
        idle(6);
        n_cmp++;
        if (q3_d.size() != e_d.size()) begin
            n_bad++; $display("FAIL rst_retain dut3 pulses: got %0d want %0d", q3_d.size(), e_d.size());
        end else foreach (e_d[i]) begin
            n_cmp++;
            if (q3_c[i] !== e_c[i] + 2 || q3_d[i] !== e_d[i] || q3_m[i] !== e_m[i]) begin
                n_bad++; $display("FAIL rst_retain dut3 #%0d: got cyc %0d d %h m %b want cyc %0d d %h m %b",
                                  i, q3_c[i], q3_d[i], q3_m[i], e_c[i] + 2, e_d[i], e_m[i]);
            end
        end
        n_cmp++;
        if (q1_d.size() != e_d.size()) begin
            n_bad++; $display("FAIL rst_retain dut1 pulses: got %0d want %0d", q1_d.size(), e_d.size());
        end else foreach (e_d[i]) begin
            n_cmp++;
            if (q1_c[i] !== e_c[i] || q1_d[i] !== e_d[i] || q1_m[i] !== e_m[i]) begin
                n_bad++; $display("FAIL rst_retain dut1 #%0d: got cyc %0d d %h m %b want cyc %0d d %h m %b",
                                  i, q1_c[i], q1_d[i], q1_m[i], e_c[i], e_d[i], e_m[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_half_fault();
        test_back_to_back();
        test_wrap();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
